// File: rtl/memshare_coladdr_skid_buf_pkg.sv
// Shared configuration for the memShare column-address skid buffer:
// address width, allocation-sequence limit, derived widths and SKID select codes.
package memShare_config_pkg;

    localparam int COL_ADDR_W        = 8;
    localparam int MAX_ALLOC_SEQ_NUM = 3;

    // Pipeline-cycle index counts 0..MAX_ALLOC_SEQ_NUM
    localparam int PIPE_IDX_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);

    // Stall-run counter must be able to hold MAX_ALLOC_SEQ_NUM+1
    localparam int RUN_W = $clog2(MAX_ALLOC_SEQ_NUM + 2);

    // Skid-controller select encoding
    localparam logic NOSKID = 1'b0;
    localparam logic SKID   = 1'b1;

    // Next pipeline-cycle index, wrapping MAX_ALLOC_SEQ_NUM back to 0
    function automatic logic [PIPE_IDX_W-1:0] next_pipe_idx(input logic [PIPE_IDX_W-1:0] idx);
        if (idx == PIPE_IDX_W'(MAX_ALLOC_SEQ_NUM)) begin
            return '0;
        end
        return idx + PIPE_IDX_W'(1);
    endfunction

endpackage

// File: rtl/memshare_coladdr_skid_buf_skid_reg2.sv
// Generic 2-entry skid register: an output register plus one parking slot.
//
// Handshake: upstream beat is taken on a rising edge where i_valid && o_ready.
// o_ready is derived only from the parking slot being empty, so it never
// depends combinationally on i_valid or i_stall. Downstream beat leaves on an
// edge where o_valid && !i_stall. Entries leave in strict arrival order.
module memShare_skid_reg2
    import memShare_config_pkg::*;
#(
    parameter int W = COL_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_stall,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_occupancy
);

    logic [W-1:0] r_out_data;
    logic         r_out_valid;
    logic [W-1:0] r_skid_data;
    logic         r_skid_valid;

    logic w_push;
    logic w_xfer;
    logic w_load;

    // Handshake qualifiers; the output register reloads when empty or draining
    always_comb begin
        w_push = i_valid & ~r_skid_valid;
        w_xfer = r_out_valid & ~i_stall;
        w_load = ~r_out_valid | w_xfer;
    end

    // Output register: parked entry has priority over a fresh push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (r_skid_valid) begin
                r_out_data  <= r_skid_data;
                r_out_valid <= 1'b1;
            end else if (w_push) begin
                r_out_data  <= i_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Parking slot: fills on a push that cannot reach the stalled output,
    // empties when its entry moves into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_load) begin
            r_skid_valid <= 1'b0;
        end else if (w_push) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

    // Status outputs
    always_comb begin
        o_ready     = ~r_skid_valid;
        o_data      = r_out_data;
        o_valid     = r_out_valid;
        o_occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
    end

endmodule

// File: rtl/memshare_coladdr_skid_buf.sv
// Column-address skid buffer between the SCU.memShare() address generator and
// the shared-memory address port. Adds pipeline-cycle index tracking and a
// sticky flag for stall runs exceeding the back-to-back limit.
module memshare_coladdr_skid_buf
    import memShare_config_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic [COL_ADDR_W-1:0] col_addr_i,
    input  logic                  col_addr_valid_i,
    output logic                  col_addr_ready_o,
    input  logic                  isColAddr_skid_i,
    input  logic                  scu_memShare_busy_i,
    input  logic                  pipeCycle_begin_i,
    output logic [COL_ADDR_W-1:0] mem_col_addr_o,
    output logic                  mem_col_addr_valid_o,
    output logic [1:0]            occupancy_o,
    output logic [PIPE_IDX_W-1:0] pipeCycle_idx_o,
    output logic                  drc_err_o
);

    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_ALLOC_SEQ_NUM + 1);

    logic                  w_stall_eff;
    logic                  w_stall_hold;
    logic [RUN_W-1:0]      w_run_next;
    logic [PIPE_IDX_W-1:0] r_pipe_idx;
    logic [RUN_W-1:0]      r_stall_run;
    logic                  r_drc_err;

    // SKID only means anything while memShare is running
    always_comb begin
        w_stall_eff  = (isColAddr_skid_i == SKID) & scu_memShare_busy_i;
        w_stall_hold = w_stall_eff & mem_col_addr_valid_o;
    end

    memShare_skid_reg2 #(
        .W(COL_ADDR_W)
    ) u_skid_reg2 (
        .clk         (sys_clk),
        .rst_n       (rstn),
        .i_data      (col_addr_i),
        .i_valid     (col_addr_valid_i),
        .o_ready     (col_addr_ready_o),
        .i_stall     (w_stall_eff),
        .o_data      (mem_col_addr_o),
        .o_valid     (mem_col_addr_valid_o),
        .o_occupancy (occupancy_o)
    );

    // Pipeline-cycle index: advances on begin pulses, parked at 0 when idle
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_pipe_idx <= '0;
        end else if (!scu_memShare_busy_i) begin
            r_pipe_idx <= '0;
        end else if (pipeCycle_begin_i) begin
            r_pipe_idx <= next_pipe_idx(r_pipe_idx);
        end
    end

    // Next stall-run length: grows while a valid output is held, saturates
    always_comb begin
        w_run_next = '0;
        if (w_stall_hold) begin
            w_run_next = (r_stall_run == RUN_LIMIT) ? r_stall_run : r_stall_run + RUN_W'(1);
        end
    end

    // Stall-run counter and sticky violation flag
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_run <= '0;
            r_drc_err   <= 1'b0;
        end else begin
            r_stall_run <= w_run_next;
            if (w_run_next == RUN_LIMIT) begin
                r_drc_err <= 1'b1;
            end
        end
    end

    // Status outputs
    always_comb begin
        pipeCycle_idx_o = r_pipe_idx;
        drc_err_o       = r_drc_err;
    end

endmodule
